sram_async_ctrl: RTL and testbench
==================================

Name: sram_async_ctrl

Overview:
- Parametrised controller for an external asynchronous SRAM/flash-style part; the default geometry is 1Mx8.
- Converts a single-beat valid/ready request interface into correctly timed CE_n/OE_n/WE_n strobes with a tristate data bus.
- Wait states are configurable; a turnaround gap follows every read.
- Retains the board heartbeat counter as a liveness indicator and sits between core logic and the SRAM pins.

Parameters:
AW, 20, address width (SRAM words = 2^AW)
DW, 8, data width
RD_CYCLES, 2, cycles OE_n is held low per read (>=1)
WR_CYCLES, 2, cycles WE_n is held low per write (>=1)
TURN_CYCLES, 1, idle cycles after a read before the next access (>=0)
CBITS, 26, heartbeat counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  controller can accept a request
i_req_we  in  1  1=write, 0=read
i_req_addr  in  AW  word address
i_req_wdata  in  DW  write data
o_rsp_valid  out  1  one-cycle pulse, read data valid
o_rsp_rdata  out  DW  read data, held until the next read completes
o_sram_addr  out  AW  SRAM address pins
o_sram_dq_out  out  DW  data driven to the SRAM
o_sram_dq_oe  out  1  1=FPGA drives DQ (top level instantiates the tristate)
i_sram_dq_in  in  DW  data from the SRAM
o_sram_ce_n  out  1  chip enable, active low
o_sram_oe_n  out  1  output enable, active low
o_sram_we_n  out  1  write enable, active low
o_led  out  1  heartbeat, counter MSB

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous active-low on i_rst_n; every flop clears immediately on assertion.
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_sram_addr=0, o_sram_dq_out=0, o_sram_dq_oe=0, ce_n=oe_n=we_n=1, state=IDLE, heartbeat counter=0.
- Output registration: all outputs are registered; no combinational path exists from inputs to pins.
- States: IDLE, READ, TURN, WSETUP, WPULSE, WHOLD. A down-counter, sized for max(RD,WR,TURN), times each state.
- IDLE:
  - o_req_ready=1, with the first 1 appearing in the first cycle after reset release.
  - Acceptance occurs on a clock edge where valid&&ready=1.
  - On acceptance: latch addr/wdata/we into o_sram_addr/o_sram_dq_out, drop ready, and go to READ or WSETUP.
- Cycle numbering: acceptance edge ends cycle 0; cycle 1 is the first cycle after it.
- Read:
  - Cycles 1..RD_CYCLES: ce_n=0, oe_n=0, dq_oe=0.
  - Edge ending cycle RD_CYCLES: o_rsp_rdata<=i_sram_dq_in and o_rsp_valid<=1, so the pulse is high for exactly cycle RD_CYCLES+1.
  - ce_n and oe_n return to 1 at that same edge.
  - TURN then occupies TURN_CYCLES cycles with all strobes high; TURN is skipped when TURN_CYCLES=0.
  - ready returns high in cycle RD_CYCLES+TURN_CYCLES+1.
- Write:
  - WSETUP, cycle 1: ce_n=0, we_n=1, dq_oe=1.
  - WPULSE, cycles 2..WR_CYCLES+1: we_n=0.
  - WHOLD, cycle WR_CYCLES+2: we_n=1, ce_n=0, dq_oe=1, data and address unchanged.
  - Then IDLE; ready is high in cycle WR_CYCLES+3.
  - Writes produce no rsp pulse.
- Address/data stability:
  - o_sram_addr and o_sram_dq_out are stable for the whole transaction and hold their last value in IDLE.
  - Request inputs are ignored outside acceptance.
- Bus safety:
  - oe_n=0 and we_n=0 never occur in the same cycle.
  - dq_oe=1 never coincides with oe_n=0.
- Back-to-back operation: with i_req_valid held high, the next request is accepted on the first edge where ready=1; there are no bubbles beyond those defined above.
- Reset mid-operation: strobes deassert immediately and asynchronously, the transaction is dropped, and no rsp pulse is produced.
- Heartbeat: the counter increments every cycle and wraps at 2^CBITS; o_led = counter[CBITS-1].
- Parameter errors: illegal values (RD_CYCLES<1, WR_CYCLES<1) raise an elaboration-time error.

Test Plan:
- Reset: assert i_rst_n=0 mid-clock -> all outputs at reset values without waiting for a clock edge; ready=1 in the first cycle after release.
- Read (defaults): request addr 0x12345, SRAM model returns 0xA5 -> oe_n low cycles 1-2; rsp_valid=1 only in cycle 3 with rdata=0xA5; ready=1 in cycle 4.
- Write then readback (defaults): write 0xFFFFF <- 0x3C -> dq_oe high cycles 1-4, we_n low cycles 2-3, ready in cycle 5; following read of 0xFFFFF returns 0x3C.
- Back-to-back stream: valid held high for alternating W/R to 8 addresses -> checker sees no oe_n/we_n overlap and no dq_oe with oe_n low; all reads match the model; exact spacing of 5 (write) / 4 (read) cycles.
- Reset mid-write: deassert i_rst_n during WPULSE -> we_n=1 asynchronously, no rsp pulse; a fresh read after release returns the pre-write contents.
- Parameter variant AW=18, DW=16, RD_CYCLES=1, TURN_CYCLES=0, CBITS=4 -> read of 0x3FFFF returns 0xBEEF with rsp in cycle 2; continuous reads accepted every 2 cycles; o_led toggles every 8 cycles.

Source files
------------

// File: rtl/sram_async_ctrl.sv
// Controller for an external asynchronous SRAM: turns single-beat valid/ready requests into
// registered CE_n/OE_n/WE_n strobes, with a registered DQ drive enable and a heartbeat LED.
module sram_async_ctrl #(
  parameter int AW          = 20,
  parameter int DW          = 8,
  parameter int RD_CYCLES   = 2,
  parameter int WR_CYCLES   = 2,
  parameter int TURN_CYCLES = 1,
  parameter int CBITS       = 26
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_dq_out,
  output logic          o_sram_dq_oe,
  input  logic [DW-1:0] i_sram_dq_in,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n,
  output logic          o_led
);

  if (RD_CYCLES < 1) begin : gen_rd_cycles_err
    $error("sram_async_ctrl: RD_CYCLES must be >= 1");
  end
  if (WR_CYCLES < 1) begin : gen_wr_cycles_err
    $error("sram_async_ctrl: WR_CYCLES must be >= 1");
  end
  if (TURN_CYCLES < 0) begin : gen_turn_cycles_err
    $error("sram_async_ctrl: TURN_CYCLES must be >= 0");
  end

  localparam int MaxRw  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MaxCyc = (MaxRw > TURN_CYCLES) ? MaxRw : TURN_CYCLES;
  // The counter is loaded with (cycles - 1), so it never holds MaxCyc itself.
  localparam int CW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CW-1:0] RdLoad   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WrLoad   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TurnLoad = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StTurn,
    StWsetup,
    StWpulse,
    StWhold
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    dq_out_q, dq_out_d;
  logic             dq_oe_q, dq_oe_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic [CBITS-1:0] hb_q;

  logic accept;
  logic cnt_last;

  assign accept   = (state_q == StIdle) && ready_q && i_req_valid;
  assign cnt_last = (cnt_q == '0);

  // State register: every flop, including the pin registers, clears on reset assertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      hb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      hb_q        <= hb_q + CBITS'(1);
    end
  end

  // Next state and dwell counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = i_req_we ? StWsetup : StRead;
          cnt_d   = i_req_we ? '0 : RdLoad;
        end
      end
      StRead: begin
        if (cnt_last) begin
          if (TURN_CYCLES > 0) begin
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StTurn: begin
        if (cnt_last) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWsetup: begin
        state_d = StWpulse;
        cnt_d   = WrLoad;
      end
      StWpulse: begin
        if (cnt_last) begin
          state_d = StWhold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWhold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are decoded from the upcoming state so every strobe leaves a flop.
  always_comb begin
    ready_d     = (state_d == StIdle);
    ce_n_d      = (state_d == StIdle) || (state_d == StTurn);
    oe_n_d      = (state_d != StRead);
    we_n_d      = (state_d != StWpulse);
    dq_oe_d     = (state_d == StWsetup) || (state_d == StWpulse) || (state_d == StWhold);
    rsp_valid_d = (state_q == StRead) && cnt_last;
    rdata_d     = rsp_valid_d ? i_sram_dq_in : rdata_q;
    addr_d      = accept ? i_req_addr : addr_q;
    dq_out_d    = accept ? i_req_wdata : dq_out_q;
  end

  assign o_req_ready   = ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_dq_out = dq_out_q;
  assign o_sram_dq_oe  = dq_oe_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_we_n   = we_n_q;
  assign o_led         = hb_q[CBITS-1];

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: a transaction-level model checks the default instance every cycle,
// directed literal checks pin the model, and a second instance covers a fast parameter variant.
module tb_sram_async_ctrl;

  localparam int RD   = 2;
  localparam int WR   = 2;
  localparam int TURN = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- default instance ----------------
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [19:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ready, a_rsp, a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_led;
  logic [7:0]  a_rdata, a_dq_out, a_dq_in;
  logic [19:0] a_saddr;

  sram_async_ctrl u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_we(a_we),
    .i_req_addr(a_addr), .i_req_wdata(a_wdata),
    .o_rsp_valid(a_rsp), .o_rsp_rdata(a_rdata),
    .o_sram_addr(a_saddr), .o_sram_dq_out(a_dq_out), .o_sram_dq_oe(a_dq_oe),
    .i_sram_dq_in(a_dq_in),
    .o_sram_ce_n(a_ce_n), .o_sram_oe_n(a_oe_n), .o_sram_we_n(a_we_n),
    .o_led(a_led)
  );

  // SRAM part model: unwritten words read as addr[7:0]^0x5A; writes commit on WE_n rising.
  logic [7:0] pin_mem [bit [19:0]];
  logic [7:0] ref_mem [bit [19:0]];

  function automatic logic [7:0] pin_rd(input logic [19:0] a);
    if (pin_mem.exists(a)) return pin_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  assign a_dq_in = a_oe_n ? 8'h00 : pin_rd(a_saddr);

  always @(posedge a_we_n) if (rst_n && !a_ce_n) pin_mem[a_saddr] = a_dq_out;

  // Transaction model: k counts cycles since the acceptance edge.
  int          cyc = 0;
  int          m_acc_cnt = 0;
  int          m_acc_cyc = 0;
  int          m_k = 0;
  bit          m_busy = 0, m_wr = 0, m_ready = 0, m_rsp = 0;
  logic [19:0] m_addr = '0;
  logic [7:0]  m_dq = '0, m_rdata = '0;
  logic [25:0] m_hb = '0;

  always begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_rsp = 0; m_k = 0;
      m_addr = '0; m_dq = '0; m_rdata = '0; m_hb = '0;
    end else begin
      m_hb++;
      m_rsp = 0;
      if (m_ready && a_valid) begin
        m_busy = 1; m_wr = a_we; m_k = 1; m_addr = a_addr; m_dq = a_wdata;
        m_acc_cnt++; m_acc_cyc = cyc;
      end else if (m_busy) begin
        m_k++;
      end
      if (m_busy && !m_wr && m_k == RD + 1) begin
        m_rsp = 1;
        m_rdata = ref_rd(m_addr);
      end
      if (m_busy && (m_wr ? (m_k == WR + 3) : (m_k == RD + TURN + 1))) begin
        if (m_wr) ref_mem[m_addr] = m_dq;
        m_busy = 0;
      end
      m_ready = !m_busy;
    end
    #1;
    chk("m_ready", a_ready, m_ready);
    chk("m_rsp_valid", a_rsp, m_rsp);
    chk("m_rdata", a_rdata, m_rdata);
    chk("m_addr", a_saddr, m_addr);
    chk("m_dq_out", a_dq_out, m_dq);
    chk("m_ce_n", a_ce_n, !(m_busy && (m_wr ? (m_k <= WR + 2) : (m_k <= RD))));
    chk("m_oe_n", a_oe_n, !(m_busy && !m_wr && m_k <= RD));
    chk("m_we_n", a_we_n, !(m_busy && m_wr && m_k >= 2 && m_k <= WR + 1));
    chk("m_dq_oe", a_dq_oe, m_busy && m_wr && m_k <= WR + 2);
    chk("m_led", a_led, m_hb[25]);
    chk("safe_oe_we", !(!a_oe_n && !a_we_n), 1);
    chk("safe_dqoe_oe", !(a_dq_oe && !a_oe_n), 1);
  end

  // Presents one request and returns at the middle of cycle 1.
  task automatic a_req(input logic we, input logic [19:0] addr, input logic [7:0] wd);
    int start;
    bit got;
    @(negedge clk);
    a_we = we; a_addr = addr; a_wdata = wd; a_valid = 1'b1;
    start = m_acc_cnt;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #2;
      got = (m_acc_cnt != start);
    end
    chk("a_accept", {31'b0, got}, 1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // ---------------- variant instance ----------------
  logic        b_valid = 1'b0;
  logic [17:0] b_addr = '0;
  logic        b_ready, b_rsp, b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_led;
  logic [15:0] b_rdata, b_dq_out, b_dq_in;
  logic [17:0] b_saddr;

  sram_async_ctrl #(
    .AW(18), .DW(16), .RD_CYCLES(1), .WR_CYCLES(2), .TURN_CYCLES(0), .CBITS(4)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(1'b0),
    .i_req_addr(b_addr), .i_req_wdata(16'h0000),
    .o_rsp_valid(b_rsp), .o_rsp_rdata(b_rdata),
    .o_sram_addr(b_saddr), .o_sram_dq_out(b_dq_out), .o_sram_dq_oe(b_dq_oe),
    .i_sram_dq_in(b_dq_in),
    .o_sram_ce_n(b_ce_n), .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n),
    .o_led(b_led)
  );

  assign b_dq_in = b_oe_n ? 16'h0000 : ((b_saddr == 18'h3FFFF) ? 16'hBEEF : 16'h1234);

  // ---------------- stimulus ----------------
  logic [19:0] s_addr [8];
  logic [7:0]  s_wd [8];
  bit [5:1] pat_dqoe = 5'b01111;
  bit [5:1] pat_wen  = 5'b11001;
  bit [5:1] pat_rdy  = 5'b10000;
  int       marks [$];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    pin_mem[20'h12345] = 8'hA5;
    ref_mem[20'h12345] = 8'hA5;

    // Reset values and first ready.
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_ce_n", a_ce_n, 1);
    chk("rst_dq_oe", a_dq_oe, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", a_ready, 0);
    @(negedge clk);
    chk("rel_ready_first_cycle", a_ready, 1);

    // Read 0x12345 -> 0xA5.
    a_req(1'b0, 20'h12345, 8'h00);
    chk("rd_c1_oe_n", a_oe_n, 0);
    chk("rd_c1_rsp", a_rsp, 0);
    @(negedge clk);
    chk("rd_c2_oe_n", a_oe_n, 0);
    chk("rd_c2_rsp", a_rsp, 0);
    @(negedge clk);
    chk("rd_c3_oe_n", a_oe_n, 1);
    chk("rd_c3_rsp", a_rsp, 1);
    chk("rd_c3_rdata", a_rdata, 8'hA5);
    chk("rd_c3_ready", a_ready, 0);
    @(negedge clk);
    chk("rd_c4_ready", a_ready, 1);
    chk("rd_c4_rsp", a_rsp, 0);

    // Write 0xFFFFF <- 0x3C, then read it back.
    a_req(1'b1, 20'hFFFFF, 8'h3C);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("wr_c%0d_dq_oe", c), a_dq_oe, pat_dqoe[c]);
      chk($sformatf("wr_c%0d_we_n", c), a_we_n, pat_wen[c]);
      chk($sformatf("wr_c%0d_ready", c), a_ready, pat_rdy[c]);
    end
    a_req(1'b0, 20'hFFFFF, 8'h00);
    repeat (2) @(negedge clk);
    chk("wr_readback", a_rdata, 8'h3C);
    repeat (2) @(negedge clk);

    // Back-to-back alternating write/read stream with valid held high.
    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 20'h00100 + 20'(i * 20'h01111);
      s_wd[i]   = 8'h10 + 8'(i * 7);
    end
    @(negedge clk);
    a_valid = 1'b1;
    a_we = 1'b1; a_addr = s_addr[0]; a_wdata = s_wd[0];
    for (int j = 0; j < 16; j++) begin
      int start, prev_cyc;
      bit got, prev_we;
      start = m_acc_cnt;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #2;
        got = (m_acc_cnt != start);
      end
      chk("b2b_accept", {31'b0, got}, 1);
      if (j > 0) chk($sformatf("b2b_spacing_%0d", j), m_acc_cyc - prev_cyc, prev_we ? 5 : 4);
      prev_cyc = m_acc_cyc;
      prev_we = a_we;
      @(negedge clk);
      if (j < 15) begin
        a_we = ((j + 1) % 2 == 0);
        a_addr = s_addr[(j + 1) / 2];
        a_wdata = s_wd[(j + 1) / 2] ^ (a_we ? 8'h00 : 8'hFF);
      end else begin
        a_valid = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    chk("b2b_last_rdata", a_rdata, s_wd[7]);

    // Reset in the middle of the write pulse.
    a_req(1'b1, 20'h00055, 8'h99);
    @(negedge clk);
    chk("mid_we_n_low", a_we_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", a_we_n, 1);
    chk("mid_rst_ce_n", a_ce_n, 1);
    chk("mid_rst_dq_oe", a_dq_oe, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_rdata", a_rdata, 8'h00);
    chk("mid_rst_addr", a_saddr, 20'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", a_ready, 1);
    a_req(1'b0, 20'h00055, 8'h00);
    repeat (2) @(negedge clk);
    chk("mid_old_data", a_rdata, 8'h0F);

    // Variant: RD_CYCLES=1, TURN_CYCLES=0, CBITS=4.
    @(negedge clk);
    b_addr = 18'h3FFFF;
    for (int i = 0; i < 10 && !b_ready; i++) @(negedge clk);
    chk("v_ready", b_ready, 1);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    chk("v_c1_oe_n", b_oe_n, 0);
    chk("v_c1_rsp", b_rsp, 0);
    @(negedge clk);
    chk("v_c2_rsp", b_rsp, 1);
    chk("v_c2_rdata", b_rdata, 16'hBEEF);
    chk("v_c2_ready", b_ready, 1);

    b_valid = 1'b1;
    marks.delete();
    for (int i = 0; i < 12; i++) begin
      if (b_ready) marks.push_back(i);
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("v_stream_count", marks.size(), 6);
    for (int i = 1; i < marks.size(); i++)
      chk($sformatf("v_stream_gap_%0d", i), marks[i] - marks[i-1], 2);

    begin
      logic prev_led;
      marks.delete();
      prev_led = b_led;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (b_led !== prev_led) marks.push_back(i);
        prev_led = b_led;
      end
    end
    chk("v_led_toggles", marks.size(), 5);
    for (int i = 1; i < marks.size(); i++)
      chk($sformatf("v_led_gap_%0d", i), marks[i] - marks[i-1], 8);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
